uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side byte FIFO that sits directly downstream of the UART RX engine.
- Accepts bytes on a valid/ready stream and buffers them.
- Presents them first-word-fall-through to the MMIO register block or DMA consumer.
- Provides fill level and status flags.
- Backpressure (in_ready low when full) holds the byte in the RX engine rather than dropping it.

Parameters:
- DEPTH, 16, number of byte entries; power of two, at least 2.
- DATA_W, 8, entry width in bits.
- AFULL_LEVEL, 12, count at or above which afull asserts; range 1..DEPTH.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all contents
- in_valid  input  1  upstream byte valid
- in_ready  output  1  FIFO can accept a byte
- in_data  input  DATA_W  upstream byte
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer accepts head
- out_data  output  DATA_W  head entry (FWFT)
- count  output  $clog2(DEPTH)+1  current fill level
- empty  output  1  count==0
- full  output  1  count==DEPTH
- afull  output  1  count>=AFULL_LEVEL
- max_level  output  $clog2(DEPTH)+1  high-water mark (see Optional Feature)

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n). All state is registered on posedge clk.
- Reset values:
  - count=0, empty=1, full=0, afull=0, out_valid=0, in_ready=1, out_data=0, max_level=0.
  - Read/write pointers are 0 and storage is cleared to 0.
- Pointers:
  - ADDR_W=$clog2(DEPTH) bits each; they wrap naturally from DEPTH-1 to 0.
  - count is a separate ADDR_W+1 bit register.
- Handshake events:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
  - in_ready = !full, registered-derived. There is no combinational path from out_ready to in_ready.
  - out_valid = !empty, with no combinational path from in_valid.
- Latency:
  - A byte pushed in cycle N is visible on out_data with out_valid=1 in cycle N+1 when the FIFO was empty.
  - out_data = storage[rd_ptr] whenever out_valid=1. It stays stable while out_valid && !out_ready.
- Simultaneous push and pop (neither empty nor full): both pointers advance and count is unchanged.
- Full: a push is blocked even if a pop occurs in the same cycle. in_ready rises the cycle after the pop.
- Empty: no pop is possible. A push makes out_valid rise the next cycle.
- Flush:
  - Has priority over push and pop in the same cycle; a push coinciding with flush is discarded.
  - Pointers and count go to 0 the next cycle; storage contents are not required to clear.
  - flush also clears max_level.
- Mid-operation reset: rst_n low returns all outputs to reset values immediately (asynchronously), regardless of the handshake in flight.
- Status flags empty, full and afull are pure decodes of the registered count and are glitch-free relative to clk.
- Stream rules: in_data is ignored when !in_valid. Upstream must hold in_valid/in_data until in_ready; the FIFO does not check this.

Optional Feature:
- Macro: UART_RX_FIFO_HWM_EN
- Defined:
  - max_level is a register updated each cycle to max(max_level, count_next).
  - It is cleared by reset or flush.
  - It saturates at DEPTH.
- Undefined: max_level is tied to 0 and no extra registers are inferred. The port always exists so the MMIO map is fixed.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_W=8.
  - Default UART_RX_FIFO_DEPTH=16 and UART_RX_FIFO_AFULL=12.
  - A status bit-index enum (ST_EMPTY, ST_FULL, ST_AFULL) used by the MMIO block.
- No sub-module. Storage is an inferred register array inside the block, and pointer/count logic is small enough to stay inline.

Test Plan:
- Reset then single push 0xA5 with out_ready=0:
  - out_valid=1 and out_data=0xA5 one cycle after the push.
  - count=1, empty=0.
  - Data holds for 10 cycles until out_ready=1, then empty=1.
- Fill with 16 bytes 0x00..0x0F with out_ready=0:
  - afull asserts at count=12; full=1 and in_ready=0 at count=16.
  - A 17th byte 0xFF is held upstream and not stored.
  - Draining yields 0x00..0x0F in order.
- Full FIFO with in_valid=1 and out_ready=1 in the same cycle:
  - Pop of 0x00 occurs and no push; count=15.
  - Next cycle in_ready=1 and the push of 0xFF is accepted; 0xFF is last out.
- Half-full (count=8), continuous push and pop for 32 cycles: count stays 8, and output order matches input order across pointer wrap.
- count=5 with flush=1 and in_valid=1 in the same cycle:
  - Next cycle count=0, empty=1, out_valid=0.
  - The coinciding byte is not stored; max_level=0 when HWM is enabled.
- HWM enabled: push 9 bytes, pop 4, push 2 -> max_level=9. Without the macro, max_level=0 throughout.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: data width, RX FIFO defaults and the status bit map
// that the MMIO block uses to pack empty/full/afull into its status register.
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;
  localparam int UART_RX_FIFO_AFULL = 12;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_AFULL = 2'd2
  } uart_st_bit_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through RX byte FIFO with fill level and status flags.
// Define UART_RX_FIFO_HWM_EN to make max_level track the high-water mark.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = UART_RX_FIFO_DEPTH,
  parameter int DATA_W      = UART_DATA_W,
  parameter int AFULL_LEVEL = UART_RX_FIFO_AFULL
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     afull,
  output logic [$clog2(DEPTH):0]   max_level
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_nxt;
  logic              push, pop;

  // Flags decode only the registered count, so ready/valid never see
  // a combinational path from the opposite side of the stream.
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign afull     = (count >= CNT_W'(AFULL_LEVEL));
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else
      count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      count <= count_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= in_data;
          wr_ptr      <= wr_ptr + ADDR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + ADDR_W'(1);
      end
    end
  end

`ifdef UART_RX_FIFO_HWM_EN
  // count_nxt never exceeds DEPTH, so the mark saturates there by construction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      max_level <= '0;
    else if (flush)
      max_level <= '0;
    else if (count_nxt > max_level)
      max_level <= count_nxt;
  end
`else
  assign max_level = '0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (default DEPTH=16, AFULL=12); HWM
// expectations follow UART_RX_FIFO_HWM_EN.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [4:0] count, max_level;
  logic       empty, full, afull;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx_fifo dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .empty(empty), .full(full), .afull(afull),
    .max_level(max_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [7:0] d);
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

`ifdef UART_RX_FIFO_HWM_EN
  localparam bit HWM = 1'b1;
`else
  localparam bit HWM = 1'b0;
`endif

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    #12;
    // reset state
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", afull, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_max_level", max_level, 0);
    rst_n = 1'b1;
    tick();

    // single push, data held while stalled
    push1(8'hA5);
    chk("p1_out_valid", out_valid, 1);
    chk("p1_out_data", out_data, 8'hA5);
    chk("p1_count", count, 1);
    chk("p1_empty", empty, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("p1_hold", out_data, 8'hA5);
    end
    pop1();
    chk("p1_drained", empty, 1);

    // fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      push1(8'(i));
      chk("fill_count", count, i + 1);
      chk("fill_afull", afull, (i + 1 >= 12) ? 1 : 0);
      chk("fill_full", full, (i + 1 == 16) ? 1 : 0);
    end
    chk("full_in_ready", in_ready, 0);
    chk("full_max_level", max_level, HWM ? 16 : 0);
    in_valid = 1'b1; in_data = 8'hFF;
    tick();
    chk("blocked_count", count, 16);
    // full with pop and push in the same cycle: only the pop happens
    chk("fp_head", out_data, 8'h00);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("fp_count", count, 15);
    chk("fp_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("fp_refill", count, 16);
    out_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk("drain_data", out_data, i);
      tick();
    end
    chk("drain_last", out_data, 8'hFF);
    tick();
    out_ready = 1'b0;
    chk("drain_empty", empty, 1);

    // half full, streaming across pointer wrap
    for (int i = 0; i < 8; i++) push1(8'h40 + 8'(i));
    chk("hf_count", count, 8);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      in_data = 8'h50 + 8'(k);
      chk("hf_data", out_data, (k < 8) ? (8'h40 + k) : (8'h50 + k - 8));
      tick();
      chk("hf_level", count, 8);
    end
    in_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk("hf_tail", out_data, 8'h68 + j);
      tick();
    end
    out_ready = 1'b0;
    chk("hf_empty", empty, 1);

    // flush with a coinciding push
    for (int i = 0; i < 5; i++) push1(8'h20 + 8'(i));
    chk("fl_pre", count, 5);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_count", count, 0);
    chk("fl_empty", empty, 1);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_max_level", max_level, 0);
    push1(8'h11);
    chk("fl_next_data", out_data, 8'h11);
    chk("fl_next_count", count, 1);
    pop1();

    // high-water mark: push 9, pop 4, push 2
    for (int i = 0; i < 9; i++) push1(8'h30 + 8'(i));
    for (int i = 0; i < 4; i++) pop1();
    push1(8'h3A); push1(8'h3B);
    chk("hwm_count", count, 7);
    chk("hwm_level", max_level, HWM ? 9 : 0);
    chk("hwm_head", out_data, 8'h34);

    // asynchronous reset mid-operation
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_max_level", max_level, 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
